addr_counter_n: RTL and testbench
=================================

Name: addr_counter_n

Overview:
- Parametrised, fully synchronous up/down address counter; next generation of the 5-bit ripple address counter.
- All state is clocked on clk; there are no derived clocks.
- Adds enable, direction, parallel load, synchronous clear, programmable modulo, wrap-or-saturate mode, and terminal/wrap status.
- Drives address buses for ROM/RAM sequencing, e.g. FPU coefficient tables and test-pattern memories.

Parameters:
- WIDTH, 5: counter/address width in bits, minimum 1.
- MAX_COUNT, 2**WIDTH-1: highest count value (modulo-1); must be in 1..2**WIDTH-1.
- RST_VAL, 0: value loaded on reset and on clear; must be <= MAX_COUNT.
- PRESCALE, 4: enabled cycles per count step; used only with the optional feature; must be >= 1.

Ports:
- clk  input  1  Clock; all logic is on the rising edge.
- rst  input  1  Reset, synchronous, active-high.
- en_i  input  1  Count enable.
- up_dn_i  input  1  Direction: 1 = up, 0 = down.
- sat_i  input  1  Limit mode: 1 = saturate at limit, 0 = wrap.
- clr_i  input  1  Synchronous clear to RST_VAL.
- load_i  input  1  Parallel load strobe.
- load_val_i  input  WIDTH  Load value.
- address_o  output  WIDTH  Current count, registered.
- tc_o  output  1  Terminal count, combinational: address_o == MAX_COUNT when up_dn_i=1; address_o == 0 when up_dn_i=0.
- wrap_o  output  1  Registered one-cycle pulse; high in the cycle after a wrap step.
- sat_o  output  1  Registered; high while an enabled step was blocked by the limit in saturate mode.

Behaviour:
- Reset: when rst=1 at a clock edge, address_o=RST_VAL, wrap_o=0, sat_o=0; the prescaler (if present) is cleared. Reset mid-count discards any pending step, clear or load in that cycle.
- Per-edge priority is rst > clr_i > load_i > en_i step > hold.
- clr_i: address_o<=RST_VAL, wrap_o<=0, sat_o<=0.
- load_i: address_o<=min(load_val_i, MAX_COUNT), so out-of-range values clamp to MAX_COUNT. wrap_o<=0, sat_o<=0.
- Step: a step occurs when en_i=1 and no higher-priority event is active.
  - Up, address<MAX_COUNT: address+1.
  - Down, address>0: address-1.
  - Up at MAX_COUNT, sat_i=0: wraps to 0; wrap_o<=1.
  - Down at 0, sat_i=0: wraps to MAX_COUNT; wrap_o<=1.
  - Either limit with sat_i=1: address holds; sat_o<=1.
- Any edge that is not a wrap step drives wrap_o<=0, so wrap_o is exactly one cycle per wrap.
- sat_o clears on the first edge that is not a blocked saturate step (move, idle, clr_i, load_i or rst).
- en_i=0 with no clr_i/load_i: address holds, wrap_o<=0, sat_o<=0.
- Latency: inputs sampled at edge N are reflected on address_o after edge N.
- Direction or mode may change on any cycle with no settling cycle required; each edge uses the current up_dn_i/sat_i.
- Arithmetic is WIDTH bits with explicit compare-to-limit. Non-power-of-two MAX_COUNT must never reach values above MAX_COUNT.

Optional Feature:
- Macro: ADDR_CNT_PRESCALE_EN.
- Defined: a prescaler counts enabled cycles; a step occurs only on the enabled cycle where the prescaler equals PRESCALE-1, after which the prescaler returns to 0.
- The prescaler clears on rst, clr_i and load_i, and holds while en_i=0.
- tc_o additionally requires the prescaler to be at PRESCALE-1.
- Not defined: the prescaler is absent; every enabled cycle steps; PRESCALE is ignored.

Decomposition:
- Shared package addr_cnt_pkg:
  - typedef cnt_dir_e {CNT_DOWN=0, CNT_UP=1};
  - typedef cnt_mode_e {CNT_WRAP=0, CNT_SAT=1};
  - constant ADDR_CNT_DEF_WIDTH=5.
- One natural sub-module, addr_cnt_prescaler (clk, rst, clr, en_i, tick_o), instantiated only under ADDR_CNT_PRESCALE_EN.
- The core next-state logic stays in one always_ff plus one always_comb.

Test Plan:
- Reset and up-count wrap, WIDTH=5 default: rst 1 cycle then en_i=1, up_dn_i=1, sat_i=0 for 33 cycles -> address 0,1..31,0,1. wrap_o high exactly one cycle, after the 31->0 edge. tc_o high while address=31.
- Down saturate, MAX_COUNT=19: load 2, then en_i=1, up_dn_i=0, sat_i=1 for 5 cycles -> 1, 0, 0, 0, 0. sat_o high from the third step onward, low one cycle after en_i drops. wrap_o never asserts.
- Non-power-of-two modulo, MAX_COUNT=19, wrap mode: up-count from 18 -> 19, 0, 1 with one wrap_o pulse. Load 25 -> address=19 (clamped).
- Priority: load_i=1 with load_val_i=7, clr_i=1 and en_i=1 in the same cycle -> address=RST_VAL (0). Next cycle load_i=1, en_i=1 -> address=7, not 8.
- Reset mid-operation: counting up at 12 with en_i=1, assert rst for one cycle -> address=0, wrap_o=0, sat_o=0. Counting resumes 1, 2 on the following edges.
- ADDR_CNT_PRESCALE_EN, PRESCALE=4: en_i=1, up_dn_i=1 for 12 cycles from 0 -> address increments on the 4th, 8th and 12th edges to reach 3. Dropping en_i for 2 cycles mid-interval delays the next step by 2 cycles.

Source files
------------

// File: rtl/addr_cnt_pkg.sv
// Shared types and constants for the addr_counter_n address counter family.
package addr_cnt_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int ADDR_CNT_DEF_WIDTH = 5;

endpackage

// File: rtl/addr_cnt_prescaler.sv
// Enabled-cycle prescaler: tick_o is high while the phase counter sits on its
// last phase, so a step is taken on the enabled cycle that ends the interval.
module addr_cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en_i,
    output logic tick_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase_q <= '0;
        end else if (en_i) begin
            phase_q <= (phase_q == LAST) ? '0 : phase_q + 1'b1;
        end
    end

    assign tick_o = (phase_q == LAST);

endmodule

// File: rtl/addr_counter_n.sv
// Synchronous up/down address counter with load, clear, modulo, wrap/saturate
// and status flags. Define ADDR_CNT_PRESCALE_EN to divide steps by PRESCALE.
module addr_counter_n
    import addr_cnt_pkg::*;
#(
    parameter int WIDTH     = ADDR_CNT_DEF_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int RST_VAL   = 0,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             sat_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] address_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] addr_q, addr_n;
    logic             wrap_q, wrap_n;
    logic             sat_q, sat_n;
    logic             tick;
    logic             at_max, at_zero;
    cnt_dir_e         dir;
    cnt_mode_e        mode;

    assign dir     = cnt_dir_e'(up_dn_i);
    assign mode    = cnt_mode_e'(sat_i);
    assign at_max  = (addr_q == MAX_C);
    assign at_zero = (addr_q == '0);

`ifdef ADDR_CNT_PRESCALE_EN
    addr_cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_i | load_i),
        .en_i   (en_i),
        .tick_o (tick)
    );
`else
    // Without the prescaler every enabled cycle is a step.
    assign tick = (PRESCALE >= 1) ? 1'b1 : 1'b1;
`endif

    always_comb begin
        addr_n = addr_q;
        wrap_n = 1'b0;
        sat_n  = 1'b0;
        if (clr_i) begin
            addr_n = RST_C;
        end else if (load_i) begin
            addr_n = (load_val_i > MAX_C) ? MAX_C : load_val_i;
        end else if (en_i && tick) begin
            if (dir == CNT_UP) begin
                if (!at_max) begin
                    addr_n = addr_q + 1'b1;
                end else if (mode == CNT_SAT) begin
                    sat_n = 1'b1;
                end else begin
                    addr_n = '0;
                    wrap_n = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    addr_n = addr_q - 1'b1;
                end else if (mode == CNT_SAT) begin
                    sat_n = 1'b1;
                end else begin
                    addr_n = MAX_C;
                    wrap_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= RST_C;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            addr_q <= addr_n;
            wrap_q <= wrap_n;
            sat_q  <= sat_n;
        end
    end

    assign address_o = addr_q;
    assign wrap_o    = wrap_q;
    assign sat_o     = sat_q;
    assign tc_o      = ((dir == CNT_UP) ? at_max : at_zero) && tick;

endmodule

// File: tb/tb_addr_counter_n.sv
// Bench for addr_counter_n: two instances (full 5-bit range and modulo-20)
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_addr_counter_n;

    localparam int PRESC = 4;

    logic       clk = 1'b0;
    logic       rst, en_i, up_dn_i, sat_i, clr_i, load_i;
    logic [4:0] load_val_i;

    logic [4:0] addr0, addr1;
    logic       tc0, tc1, wrap0, wrap1, sat0, sat1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addr_counter_n #(.WIDTH(5), .PRESCALE(PRESC)) dut0 (
        .clk(clk), .rst(rst), .en_i(en_i), .up_dn_i(up_dn_i), .sat_i(sat_i),
        .clr_i(clr_i), .load_i(load_i), .load_val_i(load_val_i),
        .address_o(addr0), .tc_o(tc0), .wrap_o(wrap0), .sat_o(sat0)
    );

    addr_counter_n #(.WIDTH(5), .MAX_COUNT(19), .RST_VAL(0), .PRESCALE(PRESC)) dut1 (
        .clk(clk), .rst(rst), .en_i(en_i), .up_dn_i(up_dn_i), .sat_i(sat_i),
        .clr_i(clr_i), .load_i(load_i), .load_val_i(load_val_i),
        .address_o(addr1), .tc_o(tc1), .wrap_o(wrap1), .sat_o(sat1)
    );

    // Behavioural model: one entry per instance.
    int  m_max[2] = '{31, 19};
    int  m_addr[2];
    bit  m_wrap[2];
    bit  m_sat[2];
    int  m_pre[2];
    bit  m_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit step;
            if (rst) begin
                m_addr[i] = 0; m_wrap[i] = 0; m_sat[i] = 0; m_pre[i] = 0;
            end else if (clr_i) begin
                m_addr[i] = 0; m_wrap[i] = 0; m_sat[i] = 0; m_pre[i] = 0;
            end else if (load_i) begin
                m_addr[i] = (int'(load_val_i) > m_max[i]) ? m_max[i] : int'(load_val_i);
                m_wrap[i] = 0; m_sat[i] = 0; m_pre[i] = 0;
            end else if (en_i) begin
                step = 1'b1;
`ifdef ADDR_CNT_PRESCALE_EN
                step = (m_pre[i] == PRESC - 1);
                m_pre[i] = (m_pre[i] + 1) % PRESC;
`endif
                m_wrap[i] = 0; m_sat[i] = 0;
                if (step) begin
                    if (up_dn_i) begin
                        if (m_addr[i] < m_max[i]) m_addr[i] = m_addr[i] + 1;
                        else if (sat_i)           m_sat[i] = 1;
                        else begin m_addr[i] = 0; m_wrap[i] = 1; end
                    end else begin
                        if (m_addr[i] > 0) m_addr[i] = m_addr[i] - 1;
                        else if (sat_i)    m_sat[i] = 1;
                        else begin m_addr[i] = m_max[i]; m_wrap[i] = 1; end
                    end
                end
            end else begin
                m_wrap[i] = 0; m_sat[i] = 0;
            end
        end
        if (rst) m_valid = 1'b1;
    end

    function automatic bit model_tc(input int i);
        bit t;
        t = up_dn_i ? (m_addr[i] == m_max[i]) : (m_addr[i] == 0);
`ifdef ADDR_CNT_PRESCALE_EN
        t = t && (m_pre[i] == PRESC - 1);
`endif
        return t;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("addr0", int'(addr0), m_addr[0]);
            check("wrap0", int'(wrap0), int'(m_wrap[0]));
            check("sat0",  int'(sat0),  int'(m_sat[0]));
            check("tc0",   int'(tc0),   int'(model_tc(0)));
            check("addr1", int'(addr1), m_addr[1]);
            check("wrap1", int'(wrap1), int'(m_wrap[1]));
            check("sat1",  int'(sat1),  int'(m_sat[1]));
            check("tc1",   int'(tc1),   int'(model_tc(1)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; en_i = 0; up_dn_i = 1; sat_i = 0; clr_i = 0; load_i = 0; load_val_i = '0;
    endtask

    initial begin
        int wc;
        int tcc;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        cyc(1);
        rst = 0;
        check("rst_addr0", int'(addr0), 0);
        check("rst_wrap0", int'(wrap0), 0);
        check("rst_sat0",  int'(sat0),  0);

`ifndef ADDR_CNT_PRESCALE_EN
        // Up-count through the full range with a single wrap.
        en_i = 1; up_dn_i = 1; sat_i = 0;
        wc = 0; tcc = 0;
        for (int k = 0; k < 33; k++) begin
            if (tc0) tcc++;
            cyc(1);
            if (wrap0) wc++;
        end
        check("lit_up33_addr0", int'(addr0), 1);
        check("lit_up33_addr1", int'(addr1), 13);
        check("lit_up33_wraps", wc, 1);
        check("lit_up33_tc",    tcc, 1);

        // Down saturate on the modulo-20 instance.
        en_i = 0; load_i = 1; load_val_i = 5'd2; cyc(1); load_i = 0;
        en_i = 1; up_dn_i = 0; sat_i = 1;
        cyc(2);
        check("lit_dsat_addr1_a", int'(addr1), 0);
        check("lit_dsat_sat1_a",  int'(sat1),  0);
        cyc(1);
        check("lit_dsat_sat1_b",  int'(sat1),  1);
        cyc(2);
        check("lit_dsat_addr1_b", int'(addr1), 0);
        check("lit_dsat_wrap1",   int'(wrap1), 0);
        en_i = 0; cyc(1);
        check("lit_dsat_sat1_c",  int'(sat1),  0);

        // Modulo-20 wrap from 18 and load clamp.
        load_i = 1; load_val_i = 5'd18; cyc(1); load_i = 0;
        en_i = 1; up_dn_i = 1; sat_i = 0;
        cyc(1); check("lit_mod_19", int'(addr1), 19);
        cyc(1); check("lit_mod_0",  int'(addr1), 0);
        check("lit_mod_wrap", int'(wrap1), 1);
        cyc(1); check("lit_mod_1",  int'(addr1), 1);
        check("lit_mod_wrapoff", int'(wrap1), 0);
        en_i = 0; load_i = 1; load_val_i = 5'd25; cyc(1); load_i = 0;
        check("lit_clamp1", int'(addr1), 19);
        check("lit_clamp0", int'(addr0), 25);

        // Priority clr > load > step.
        clr_i = 1; load_i = 1; load_val_i = 5'd7; en_i = 1; cyc(1);
        check("lit_prio_clr", int'(addr0), 0);
        clr_i = 0; cyc(1);
        check("lit_prio_load", int'(addr0), 7);
        load_i = 0; en_i = 0;

        // Reset mid-count.
        load_i = 1; load_val_i = 5'd12; cyc(1); load_i = 0;
        en_i = 1; up_dn_i = 1; rst = 1; cyc(1); rst = 0;
        check("lit_midrst_addr", int'(addr0), 0);
        cyc(2);
        check("lit_resume_addr", int'(addr0), 2);
`else
        // Prescaled stepping: one step every PRESC enabled cycles.
        en_i = 1; up_dn_i = 1; sat_i = 0;
        cyc(3); check("lit_pre_3",  int'(addr0), 0);
        cyc(1); check("lit_pre_4",  int'(addr0), 1);
        cyc(8); check("lit_pre_12", int'(addr0), 3);
        cyc(2); en_i = 0; cyc(2); en_i = 1;
        cyc(1); check("lit_pre_hold", int'(addr0), 3);
        cyc(1); check("lit_pre_step", int'(addr0), 4);
`endif

        // Randomised traffic.
        idle_inputs();
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 99) < 2);
            clr_i      = ($urandom_range(0, 99) < 3);
            load_i     = ($urandom_range(0, 99) < 6);
            en_i       = ($urandom_range(0, 99) < 80);
            up_dn_i    = ($urandom_range(0, 1) == 1);
            sat_i      = ($urandom_range(0, 3) == 0);
            load_val_i = 5'($urandom_range(0, 31));
            cyc(1);
        end
        idle_inputs();
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
